// File: rtl/mc_sequencer.sv
// Multi-cycle CPU sequencer: holds the control-unit state code, stalls on memory
// handshakes, gates write strobes, and tracks halt/illegal-code conditions.
// Optional performance counters are enabled by defining MC_SEQUENCER_PERF_CNT_EN.
//
// state | meaning
// ------+--------------------------------------------------
// 0000  | fetch (memory state, waits on mem_ready)
// 0001  | decode (only state where halt_req is honoured)
// 0011  | load (memory state)
// 0101  | store (memory state)
// other | non-memory execute/writeback codes 0010..1001
module mc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  next_state,
  input  logic        halt_req,
  input  logic        mem_ready,
  input  logic        pc_write_in,
  input  logic        pc_write_cond_in,
  input  logic        bcond,
  input  logic        ir_write_in,
  input  logic        reg_write_in,
  input  logic        mem_write_in,
  output logic [3:0]  state,
  output logic        pc_en,
  output logic        ir_en,
  output logic        reg_we,
  output logic        mem_we,
  output logic        stall,
  output logic        halted,
  output logic        illegal_state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'b0000,
    ST_DECODE = 4'b0001,
    ST_S2     = 4'b0010,
    ST_LOAD   = 4'b0011,
    ST_S4     = 4'b0100,
    ST_STORE  = 4'b0101,
    ST_S6     = 4'b0110,
    ST_S7     = 4'b0111,
    ST_S8     = 4'b1000,
    ST_S9     = 4'b1001
  } state_t;

  localparam logic [3:0] LAST_LEGAL = 4'b1001;

  state_t state_q;
  logic   halted_q;
  logic   illegal_q;

  logic is_mem;
  logic go;
  logic halt_take;
  logic advance;
  logic code_legal;

  assign is_mem     = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_STORE);
  assign stall      = is_mem & ~mem_ready & ~halted_q;
  assign go         = ~stall & ~halted_q;
  assign halt_take  = (state_q == ST_DECODE) & halt_req & ~halted_q;
  assign advance    = go & ~halt_take;
  assign code_legal = (next_state <= LAST_LEGAL);

  assign pc_en  = (pc_write_in | (pc_write_cond_in & bcond)) & go;
  assign ir_en  = ir_write_in  & go;
  assign reg_we = reg_write_in & go;
  assign mem_we = mem_write_in & go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (halt_take) begin
      state_q  <= ST_FETCH;
      halted_q <= 1'b1;
    end else if (advance) begin
      // Out-of-range codes recover to fetch rather than wedging the machine.
      if (code_legal) begin
        state_q <= state_t'(next_state);
      end else begin
        state_q   <= ST_FETCH;
        illegal_q <= 1'b1;
      end
    end
  end

  assign state         = state_q;
  assign halted        = halted_q;
  assign illegal_state = illegal_q;

`ifdef MC_SEQUENCER_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] retire_q;
  logic        retire;

  // An instruction completes when a legal transition returns to fetch.
  assign retire = advance & code_legal & (next_state == ST_FETCH) & (state_q != ST_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (!halted_q) begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`else
  assign cycle_cnt  = 32'h0;
  assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios followed by random
// stimulus, all checked against a cycle-level behavioural model.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  next_state;
  logic        halt_req, mem_ready;
  logic        pc_write_in, pc_write_cond_in, bcond;
  logic        ir_write_in, reg_write_in, mem_write_in;
  logic [3:0]  state;
  logic        pc_en, ir_en, reg_we, mem_we, stall, halted, illegal_state;
  logic [31:0] cycle_cnt, retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  int          m_st;
  bit          m_halted, m_illegal, m_valid;
  logic [31:0] m_cyc, m_ret;

  always #5 clk = ~clk;

  mc_sequencer dut (
    .clk(clk), .reset(reset), .next_state(next_state), .halt_req(halt_req),
    .mem_ready(mem_ready), .pc_write_in(pc_write_in), .pc_write_cond_in(pc_write_cond_in),
    .bcond(bcond), .ir_write_in(ir_write_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .state(state), .pc_en(pc_en), .ir_en(ir_en),
    .reg_we(reg_we), .mem_we(mem_we), .stall(stall), .halted(halted),
    .illegal_state(illegal_state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef MC_SEQUENCER_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic idle_inputs();
    reset = 0; next_state = 0; halt_req = 0; mem_ready = 1;
    pc_write_in = 0; pc_write_cond_in = 0; bcond = 0;
    ir_write_in = 0; reg_write_in = 0; mem_write_in = 0;
  endtask

  // One clock: inputs already driven; check combinational outputs, step model, check state.
  task automatic tick();
    bit mem, m_stall, ok;
    #1;
    mem     = (m_st == 0) || (m_st == 3) || (m_st == 5);
    m_stall = mem && !mem_ready && !m_halted;
    ok      = !m_stall && !m_halted;
    if (m_valid) begin
      check("stall",  {31'b0, stall},  {31'b0, m_stall});
      check("pc_en",  {31'b0, pc_en},  {31'b0, ok && (pc_write_in || (pc_write_cond_in && bcond))});
      check("ir_en",  {31'b0, ir_en},  {31'b0, ok && ir_write_in});
      check("reg_we", {31'b0, reg_we}, {31'b0, ok && reg_write_in});
      check("mem_we", {31'b0, mem_we}, {31'b0, ok && mem_write_in});
    end
    if (reset) begin
      m_st = 0; m_halted = 0; m_illegal = 0; m_cyc = 0; m_ret = 0; m_valid = 1;
    end else if (m_valid && !m_halted) begin
      m_cyc = m_cyc + 1;
      if (m_st == 1 && halt_req) begin
        m_halted = 1; m_st = 0;
      end else if (!m_stall) begin
        if (next_state > 9) begin
          m_st = 0; m_illegal = 1;
        end else begin
          if (m_st != 0 && next_state == 0) m_ret = m_ret + 1;
          m_st = next_state;
        end
      end
    end
    @(posedge clk);
    #1;
    check("state",      {28'b0, state},      m_st);
    check("halted",     {31'b0, halted},     {31'b0, m_halted});
    check("illegal",    {31'b0, illegal_state}, {31'b0, m_illegal});
    check("cycle_cnt",  cycle_cnt,  exp_cnt(m_cyc));
    check("retire_cnt", retire_cnt, exp_cnt(m_ret));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1;
    repeat (n) tick();
    reset = 0;
  endtask

  task automatic go_to(input logic [3:0] code);
    idle_inputs();
    next_state = code;
    tick();
  endtask

  initial begin
    m_valid = 0; m_halted = 0; m_illegal = 0; m_st = 0; m_cyc = 0; m_ret = 0;
    idle_inputs();
    @(negedge clk);

    // basic sequence with one retirement
    do_reset(2);
    go_to(4'b0001); go_to(4'b0110); go_to(4'b0111); go_to(4'b0000);
    check("seq_retire", retire_cnt, exp_cnt(32'd1));
    check("seq_cycles", cycle_cnt,  exp_cnt(32'd4));

    // fetch stall for three cycles
    idle_inputs();
    ir_write_in = 1; next_state = 4'b0010; mem_ready = 0;
    repeat (3) tick();
    mem_ready = 1;
    tick();
    check("stall_release_state", {28'b0, state}, 32'd2);

    // halt from decode, then frozen
    do_reset(1);
    go_to(4'b0001);
    idle_inputs(); halt_req = 1; tick();
    idle_inputs(); pc_write_in = 1; ir_write_in = 1; next_state = 4'b0011;
    repeat (10) tick();
    check("halt_frozen", {31'b0, halted}, 32'd1);
    do_reset(1);

    // conditional PC write, then unconditional write during load stall
    go_to(4'b1000);
    idle_inputs(); pc_write_cond_in = 1; bcond = 0; next_state = 4'b1000; tick();
    bcond = 1; next_state = 4'b0011; tick();
    idle_inputs(); mem_ready = 0; pc_write_in = 1; next_state = 4'b0000; tick(); tick();
    mem_ready = 1; tick();

    // illegal code from state 0110
    go_to(4'b0001); go_to(4'b0110);
    idle_inputs(); next_state = 4'b1101; tick();
    repeat (3) go_to(4'b0001);
    check("illegal_sticky", {31'b0, illegal_state}, 32'd1);
    do_reset(1);

`ifdef MC_SEQUENCER_PERF_CNT_EN
    // counter wrap
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFE;
    idle_inputs(); next_state = 4'b0001;
    tick(); check("wrap_ffff", cycle_cnt, 32'hFFFF_FFFF);
    idle_inputs(); next_state = 4'b0010;
    tick(); check("wrap_0", cycle_cnt, 32'h0);
    tick(); check("wrap_1", cycle_cnt, 32'h1);
`endif

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 49) == 0);
      next_state       = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 9) : $urandom_range(10, 15));
      halt_req         = ($urandom_range(0, 19) == 0);
      mem_ready        = ($urandom_range(0, 9) < 7);
      pc_write_in      = 1'($urandom);
      pc_write_cond_in = 1'($urandom);
      bcond            = 1'($urandom);
      ir_write_in      = 1'($urandom);
      reg_write_in     = 1'($urandom);
      mem_write_in     = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 next_state  in  4  next-state code {N3,N2,N1,N0} from control unit.
REQ-004 halt_req  in  1  ecall decode indication (is_halted) from control unit.
REQ-005 mem_ready  in  1  memory handshake; access completes in cycle sampled high.
REQ-006 pc_write_in, pc_write_cond_in, bcond  in  1 each  raw PC controls and branch compare result.
REQ-007 ir_write_in, reg_write_in, mem_write_in  in  1 each  raw write strobes from control unit.
REQ-008 state  out  4  current state {S3,S2,S1,S0}, fed back to control unit.
REQ-009 pc_en, ir_en, reg_we, mem_we  out  1 each  gated write enables.
REQ-010 stall  out  1  combinational; current memory access not complete.
REQ-011 halted  out  1  sticky halt flag.
REQ-012 illegal_state  out  1  sticky flag; next_state code outside 0000..1001 taken.
REQ-013 cycle_cnt, retire_cnt  out  32 each  performance counters.

Function
REQ-014 Memory states SHALL be 0000 (fetch), 0011 (load), 0101 (store); all others non-memory.
REQ-015 stall SHALL = (state is memory state) & ~mem_ready & ~halted; mem_ready ignored in non-memory states.
REQ-016 When stall=0 and halted=0, state SHALL load next_state at the rising edge; single-cycle latency.
REQ-017 When stall=1, state SHALL hold; all gated write enables SHALL be 0 that cycle.
REQ-018 pc_en SHALL = (pc_write_in | (pc_write_cond_in & bcond)) & ~stall & ~halted.
REQ-019 ir_en, reg_we, mem_we SHALL = respective raw input & ~stall & ~halted.
REQ-020 halt_req=1 while state=0001 SHALL set halted at the next edge and force state to 0000; halt_req in other states SHALL be ignored.
REQ-021 Once halted=1: state frozen at 0000, all gated enables 0, stall 0, counters frozen; only reset clears it.
REQ-022 next_state in 1010..1111 while advancing SHALL load 0000 and set illegal_state (sticky until reset); operation continues.
REQ-023 cycle_cnt SHALL increment by 1 every edge with halted=0 and reset=0, including stall cycles.
REQ-024 retire_cnt SHALL increment by 1 at each edge where state!=0000, stall=0, halted=0, and loaded state=0000 (instruction completion); halt and illegal-code transitions do not retire.
REQ-025 Counters SHALL wrap modulo 2^32 (FFFF_FFFF -> 0000_0000) without flags.

Reset
REQ-026 reset=1 at an edge SHALL set state=0000, halted=0, illegal_state=0, cycle_cnt=0, retire_cnt=0.
REQ-027 reset SHALL take priority over halt_req, stall and next_state, including mid-access (pending memory access abandoned).
REQ-028 Gated outputs SHALL follow REQ-015..019 from the reset state (state 0000, fetch waiting on mem_ready) in the first cycle after reset.

Configuration
REQ-029 Macro MC_SEQUENCER_PERF_CNT_EN: defined -> cycle_cnt and retire_cnt implemented per REQ-023..025.
REQ-030 Not defined -> no counter registers; cycle_cnt and retire_cnt SHALL be tied to 32'h0; all other behaviour unchanged.

Verification
REQ-031 reset 2 cycles, mem_ready=1, next_state sequence 0001,0110,0111,0000 -> state follows with one-cycle lag; retire_cnt=1 after 4th edge; cycle_cnt=4.
REQ-032 state=0000, mem_ready=0 for 3 cycles then 1, ir_write_in=1 -> state holds 0000 for 3 edges, stall=1, ir_en=0; then ir_en=1, state=next_state; cycle_cnt +4.
REQ-033 state=0001, halt_req=1 -> halted=1, state=0000 next edge; 10 further cycles with pc_write_in=1: pc_en=0, counters unchanged; reset clears halted.
REQ-034 state=1000, pc_write_cond_in=1, bcond=0 then 1 -> pc_en 0 then 1; pc_write_in=1 during load stall -> pc_en=0.
REQ-035 next_state=1101 in state 0110 -> state=0000, illegal_state=1, retire_cnt unchanged; remains 1 until reset.
REQ-036 Preload cycle_cnt near FFFF_FFFE (force), run 3 cycles -> FFFF_FFFF, 0000_0000, 0000_0001; rerun REQ-031 without macro -> counters always 0.
